display_timing: RTL

Generates raster timing for the 1280x1024 display path. It produces the pixel coordinates (x, y), the active-area qualifier (valid) and the sync strobes (hsync, vsync) that the wave display and VGA output stages consume. It also emits single-cycle line and frame markers for frame-synchronous logic such as sample-buffer swapping. It is a pure counter/decoder block with a pixel-enable input, so it can run from a clock faster than the pixel rate.

---
 rtl/display_timing.sv | 104 ++++++++++
 1 files changed

// File: rtl/display_timing.sv
// Raster timing generator: pixel/line counters with registered coordinate, active-area,
// sync and line/frame-start outputs, advanced by a pixel enable.
module display_timing #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 48,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 248,
  parameter int   V_ACTIVE = 1024,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 38,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        valid_q, valid_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end

    // Outputs decode the next position so they line up with the counters after the edge;
    // with pix_en low the next position is the current one, so they simply hold.
    valid_d       = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    x_d           = valid_d ? h_cnt_d : '0;
    y_d           = valid_d ? v_cnt_d[9:0] : '0;
    hsync_d       = ((h_cnt_d >= H_SYNC_BEG) && (h_cnt_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_cnt_d >= V_SYNC_BEG) && (v_cnt_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = pix_en && (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_cnt_d == '0);
  end

  // Reset parks on the last pixel so the first advance lands on (0,0) with a frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      x_q           <= '0;
      y_q           <= '0;
      valid_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      valid_q       <= valid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
